// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: FSM states,
// opcode/funct values, ALU_Control codes and mux select encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type Funct field to an ALU_Control code; purely combinational.
// Unrecognised Funct values fall back to add.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int ALUC_W = 3
) (
    input  logic [OP_W-1:0]   i_funct,
    output logic [ALUC_W-1:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALUC_W'(ALU_ADD);
        case (i_funct)
            OP_W'(FN_ADD): o_alu_ctrl = ALUC_W'(ALU_ADD);
            OP_W'(FN_SUB): o_alu_ctrl = ALUC_W'(ALU_SUB);
            OP_W'(FN_AND): o_alu_ctrl = ALUC_W'(ALU_AND);
            OP_W'(FN_OR):  o_alu_ctrl = ALUC_W'(ALU_OR);
            OP_W'(FN_SLT): o_alu_ctrl = ALUC_W'(ALU_SLT);
            default:       o_alu_ctrl = ALUC_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: 2-5 cycles per instruction (illegal opcodes 2).
// Outputs are Moore-style from state; no backpressure, one instruction at a time.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   Opcode,
    input  logic [OP_W-1:0]   Funct,
    input  logic              Zero_Flag,
    output logic              PCWrite,
    output logic              IorD,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [ALUC_W-1:0] ALU_Control,
    output logic [1:0]        PCSrc,
    output logic              instr_done,
    output logic              illegal_op
);

    state_t              r_state;
    state_t              w_next;
    state_t              w_out_state;
    logic [ALUC_W-1:0]   w_funct_alu;

    alu_decoder #(
        .OP_W   (OP_W),
        .ALUC_W (ALUC_W)
    ) u_alu_decoder (
        .i_funct    (Funct),
        .o_alu_ctrl (w_funct_alu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (Opcode)
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):    w_next = MEMADR;
                    OP_W'(OP_RTYPE): w_next = EXEC;
                    OP_W'(OP_BEQ):   w_next = BRANCH;
                    OP_W'(OP_ADDI):  w_next = ADDIEX;
                    OP_W'(OP_J):     w_next = JUMP;
                    default:         w_next = FETCH;
                endcase
            end
            MEMADR: w_next = (Opcode == OP_W'(OP_LW)) ? MEMRD : MEMWR;
            MEMRD:  w_next = MEMWB;
            EXEC:   w_next = ALUWB;
            ADDIEX: w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    // During reset the outputs show FETCH decoding with every enable held low.
    assign w_out_state = rst ? FETCH : r_state;

    always_comb begin
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALU_Control = ALUC_W'(ALU_AND);
        PCSrc       = PCSRC_ALU;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (w_out_state)
            FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ALU_Control = ALUC_W'(ALU_ADD);
                PCWrite     = 1'b1;
            end
            DECODE: begin
                ALUSrcB     = SRCB_IMM_SH;
                ALU_Control = ALUC_W'(ALU_ADD);
                case (Opcode)
                    OP_W'(OP_LW), OP_W'(OP_SW), OP_W'(OP_RTYPE),
                    OP_W'(OP_BEQ), OP_W'(OP_ADDI), OP_W'(OP_J): illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALU_Control = ALUC_W'(ALU_ADD);
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            EXEC: begin
                ALUSrcA     = 1'b1;
                ALU_Control = w_funct_alu;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALUC_W'(ALU_SUB);
                PCSrc       = PCSRC_ALUOUT;
                PCWrite     = Zero_Flag;
                instr_done  = 1'b1;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCSrc      = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
        if (rst) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed probe table, reset corner cases,
// and a random instruction stream against an instruction-level model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero_Flag = 1'b0;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_Control;
    logic [1:0] PCSrc;
    logic       instr_done, illegal_op;

    multicycle_control #(.OP_W(6), .ALUC_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .Funct       (Funct),
        .Zero_Flag   (Zero_Flag),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALU_Control (ALU_Control),
        .PCSrc       (PCSrc),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, iord, memw, irw, regdst, m2r, regw, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic [1:0] pcsrc;
        logic       done, ill;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cyc;
        out_t       exp;
    } vec_t;

    out_t got;
    assign got = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALU_Control, PCSrc, instr_done, illegal_op};

    int n_checks = 0;
    int n_pass = 0;
    vec_t tbl[$];

    function automatic out_t mk(input logic pcw, iord, memw, irw, regdst, m2r, regw, srca,
                                input logic [1:0] srcb, input logic [2:0] alu,
                                input logic [1:0] pcsrc, input logic done, ill);
        out_t o;
        o.pcw = pcw; o.iord = iord; o.memw = memw; o.irw = irw;
        o.regdst = regdst; o.m2r = m2r; o.regw = regw; o.srca = srca;
        o.srcb = srcb; o.alu = alu; o.pcsrc = pcsrc; o.done = done; o.ill = ill;
        return o;
    endfunction

    // Cycles an instruction occupies, counting its FETCH.
    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'b100011:                       return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010:            return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs in cycle k (1 = FETCH) of an instruction.
    function automatic out_t ref_out(input logic [5:0] op, f, input logic z, input int k);
        out_t o;
        o = '0;
        if (k == 1) return mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,0);
        if (k == 2) return mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,(instr_len(op) == 2));
        case (op)
            6'b100011, 6'b101011: begin
                if (k == 3) o = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
                else if (op == 6'b100011 && k == 4) o = mk(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0);
                else if (op == 6'b100011 && k == 5) o = mk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,1,0);
                else if (op == 6'b101011 && k == 4) o = mk(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,1,0);
            end
            6'b000000: begin
                if (k == 3) o = mk(0,0,0,0,0,0,0,1,2'b00,funct_alu(f),2'b00,0,0);
                else        o = mk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1,0);
            end
            6'b001000: begin
                if (k == 3) o = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
                else        o = mk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,1,0);
            end
            6'b000100: o = mk(z,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0);
            6'b000010: o = mk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0);
            default:   o = '0;
        endcase
        return o;
    endfunction

    localparam out_t RST_EXP = out_t'({8'b0, 2'b01, 3'b010, 2'b00, 2'b00});

    task automatic check(input string name, input out_t g, input out_t e);
        n_checks++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, g, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_outputs", got, RST_EXP);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic add(input logic [5:0] op, f, input logic z, input int cyc, input out_t e);
        vec_t v;
        v.op = op; v.funct = f; v.zero = z; v.cyc = cyc; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic drive_cycle(input logic [5:0] op, f, input logic z);
        Opcode = op; Funct = f; Zero_Flag = z;
        @(negedge clk);
    endtask

    initial begin
        out_t fetch_v;
        fetch_v = mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,0);

        add(6'b100011, 6'h00, 0, 1, fetch_v);
        add(6'b100011, 6'h00, 0, 2, mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
        add(6'b100011, 6'h00, 0, 3, mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
        add(6'b100011, 6'h00, 0, 4, mk(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
        add(6'b100011, 6'h00, 0, 5, mk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,1,0));
        add(6'b101011, 6'h00, 0, 4, mk(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,1,0));
        add(6'b101011, 6'h00, 0, 5, fetch_v);
        add(6'b000000, 6'b100010, 0, 3, mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0));
        add(6'b000000, 6'b100010, 0, 4, mk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,1,0));
        add(6'b000000, 6'b111111, 0, 3, mk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0));
        add(6'b000000, 6'b100101, 0, 3, mk(0,0,0,0,0,0,0,1,2'b00,3'b001,2'b00,0,0));
        add(6'b000000, 6'b101010, 0, 3, mk(0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0));
        add(6'b000000, 6'b100100, 0, 3, mk(0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0,0));
        add(6'b000100, 6'h00, 1, 3, mk(1,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
        add(6'b000100, 6'h00, 0, 3, mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
        add(6'b111111, 6'h00, 0, 2, mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1));
        add(6'b111111, 6'h00, 0, 3, fetch_v);
        add(6'b000010, 6'h00, 0, 3, mk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0));
        add(6'b001000, 6'h00, 0, 3, mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
        add(6'b001000, 6'h00, 0, 4, mk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,1,0));

        foreach (tbl[i]) begin
            do_reset();
            for (int k = 1; k <= tbl[i].cyc; k++) begin
                drive_cycle(tbl[i].op, tbl[i].funct, tbl[i].zero);
                if (k == tbl[i].cyc) check($sformatf("vec%0d", i), got, tbl[i].exp);
                else begin @(posedge clk); #1; end
            end
        end

        // Reset asserted while lw sits in MEMRD: no write-back may follow.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(6'b100011, 6'h00, 1'b0);
            check("lw_pre_rst", got, ref_out(6'b100011, 6'h00, 1'b0, k));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive_cycle(6'b100011, 6'h00, 1'b0);
        check("rst_in_memrd", got, RST_EXP);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_cycle(6'b100011, 6'h00, 1'b0);
        check("fetch_after_rst", got, fetch_v);
        @(posedge clk); #1;
        drive_cycle(6'b100011, 6'h00, 1'b0);
        check("decode_after_rst", got, ref_out(6'b100011, 6'h00, 1'b0, 2));

        // Random back-to-back instruction stream.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op, f;
            logic       z;
            case ($urandom_range(0, 6))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                default: begin
                    do op = 6'($urandom); while (instr_len(op) != 2);
                end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 4))
                    0: f = 6'b100000;
                    1: f = 6'b100010;
                    2: f = 6'b100100;
                    3: f = 6'b100101;
                    default: f = 6'b101010;
                endcase
            end else begin
                f = 6'($urandom);
            end
            for (int k = 1; k <= instr_len(op); k++) begin
                z = 1'($urandom_range(0, 1));
                drive_cycle(op, f, z);
                check($sformatf("rand%0d_op%b_c%0d", n, op, k), got, ref_out(op, f, z, k));
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: OP_W, 6, width of Opcode and Funct fields.
REQ-002 Parameter: ALUC_W, 3, width of ALU_Control.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 Opcode  input  OP_W  Instr[31:26] from instruction register.
REQ-006 Funct  input  OP_W  Instr[5:0] from instruction register.
REQ-007 Zero_Flag  input  1  ALU zero result.
REQ-008 PCWrite  output  1  PC register load enable.
REQ-009 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 MemWrite  output  1  data memory write enable.
REQ-011 IRWrite  output  1  instruction register load enable.
REQ-012 RegDst  output  1  write register: 0=Instr[20:16], 1=Instr[15:11].
REQ-013 MemtoReg  output  1  write-back: 0=ALUOut, 1=Data register.
REQ-014 RegWrite  output  1  register file write enable.
REQ-015 ALUSrcA  output  1  0=PC, 1=register A.
REQ-016 ALUSrcB  output  2  00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
REQ-017 ALU_Control  output  ALUC_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-018 PCSrc  output  2  00=ALU result, 01=ALUOut (branch), 10=jump target.
REQ-019 instr_done  output  1  one-cycle pulse in an instruction's final state.
REQ-020 illegal_op  output  1  one-cycle pulse on an unsupported opcode in DECODE.

Function
REQ-021 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-022 FETCH SHALL assert IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_Control=010, PCSrc=00, PCWrite=1, then go to DECODE.
REQ-023 DECODE SHALL assert ALUSrcA=0, ALUSrcB=11, ALU_Control=010 (branch target precomputed into ALUOut), then branch on Opcode.
REQ-024 DECODE transitions: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> FETCH with illegal_op=1.
REQ-025 MEMADR: ALUSrcA=1, ALUSrcB=10, add; go to MEMRD when Opcode=100011, else MEMWR.
REQ-026 MEMRD: IorD=1 -> MEMWB; MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
REQ-027 MEMWR: IorD=1, MemWrite=1, instr_done=1 -> FETCH.
REQ-028 EXEC: ALUSrcA=1, ALUSrcB=00, ALU_Control from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other add) -> ALUWB.
REQ-029 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
REQ-030 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero_Flag in the same cycle, instr_done=1 -> FETCH.
REQ-031 ADDIEX: ALUSrcA=1, ALUSrcB=10, add -> ADDIWB; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
REQ-032 JUMP: PCSrc=10, PCWrite=1, instr_done=1 -> FETCH.
REQ-033 Outputs SHALL be combinational from current state (plus Opcode, Funct, Zero_Flag only where stated); any output not listed for a state SHALL be 0.
REQ-034 Latency in cycles incl. FETCH SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Reset
REQ-035 rst=1 at a clock edge SHALL force the state to FETCH regardless of the current state, including mid-instruction.
REQ-036 While rst=1, PCWrite, MemWrite, IRWrite, RegWrite, instr_done and illegal_op SHALL be 0; other outputs take FETCH values.
REQ-037 The first cycle after rst deasserts SHALL be a normal FETCH.

Structure
REQ-038 Package mips_ctrl_pkg SHALL hold the state enum, opcode/funct constants and ALU_Control codes.
REQ-039 Funct-to-ALU_Control decode SHALL be a sub-module alu_decoder; the FSM is in multicycle_control.

Verification
REQ-040 lw (Opcode=100011): states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5; instr_done once.
REQ-041 sw (101011): MemWrite=1 only in cycle 4 with IorD=1; RegWrite never asserted.
REQ-042 R-type Funct=100010: ALU_Control=110 in EXEC, RegDst=1 in ALUWB; Funct=111111 -> ALU_Control=010.
REQ-043 beq with Zero_Flag=1 -> PCWrite=1, PCSrc=01 in cycle 3; with Zero_Flag=0 -> PCWrite=0.
REQ-044 Opcode=111111 -> illegal_op pulse in DECODE, FETCH next cycle; j (000010) -> PCSrc=10, PCWrite=1 in cycle 3.
REQ-045 rst=1 during MEMRD of lw -> FETCH next cycle, no RegWrite pulse; write enables 0 while rst high.
